// File: rtl/rf_stream_pkg.sv
// ============================================================================
// Module      : rf_stream_pkg
// Description : Shared geometry, FSM encoding and pointer helper for the
//               lane-masked register-file streamer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rf_stream_pkg;

    localparam int DEPTH   = 10;
    localparam int LANES   = 4;
    localparam int LANE_W  = 16;
    localparam int MAX_LEN = DEPTH * LANES;

    localparam int PTR_W   = 4;
    localparam int LEN_W   = 6;
    localparam int LANE_CW = 2;
    localparam int ENTRY_W = LANES * LANE_W;

    localparam logic OP_WR = 1'b0;
    localparam logic OP_RD = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_WR_COLLECT = 3'd1,
        ST_WR_COMMIT  = 3'd2,
        ST_RD_FETCH   = 3'd3,
        ST_RD_DRAIN   = 3'd4
    } state_t;

    // Entry pointers wrap from the last entry back to entry 0.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/rf_lane_streamer.sv
// ============================================================================
// Module      : rf_lane_streamer
// Description : Burst controller turning 16-bit word streams into lane-masked
//               register-file writes (port A) and entry reads (port B).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rf_lane_streamer
    import rf_stream_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,

    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic                 cmd_op,
    input  logic [PTR_W-1:0]     cmd_base,
    input  logic [LEN_W-1:0]     cmd_len,
    output logic                 err,
    output logic                 busy,

    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [LANE_W-1:0]    in_data,

    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [LANE_W-1:0]    out_data,

    output logic [PTR_W-1:0]     rf_A,
    output logic [ENTRY_W-1:0]   rf_DIA,
    output logic [LANES-1:0]     rf_MUXA,
    output logic                 rf_CSA,
    output logic                 rf_WEAN,
    output logic                 rf_OEA,

    output logic [PTR_W-1:0]     rf_B,
    output logic                 rf_CSB,
    output logic                 rf_WEBN,
    output logic                 rf_OEB,
    input  logic [ENTRY_W-1:0]   rf_DOB
);

    state_t               r_state;
    logic [PTR_W-1:0]     r_ptr;
    logic [LANE_CW-1:0]   r_lane;
    logic [LEN_W-1:0]     r_remaining;
    logic [ENTRY_W-1:0]   r_stage;
    logic [LANES-1:0]     r_mask;
    logic [ENTRY_W-1:0]   r_rdbuf;
    logic                 r_err;

    logic                 w_cmd_bad;
    logic                 w_last_lane;
    logic                 w_last_word;

    assign w_cmd_bad   = (cmd_len == '0) ||
                         (cmd_len > LEN_W'(MAX_LEN)) ||
                         (cmd_base >= PTR_W'(DEPTH));
    assign w_last_lane = (r_lane == LANE_CW'(LANES - 1));
    assign w_last_word = (r_remaining == LEN_W'(1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_lane      <= '0;
            r_remaining <= '0;
            r_stage     <= '0;
            r_mask      <= '0;
            r_rdbuf     <= '0;
            r_err       <= 1'b0;
        end else begin
            r_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (cmd_valid) begin
                        r_ptr       <= cmd_base;
                        r_remaining <= cmd_len;
                        r_lane      <= '0;
                        r_mask      <= '0;
                        if (w_cmd_bad)
                            r_err <= 1'b1;
                        else if (cmd_op == OP_RD)
                            r_state <= ST_RD_FETCH;
                        else
                            r_state <= ST_WR_COLLECT;
                    end
                end

                ST_WR_COLLECT: begin
                    if (in_valid) begin
                        r_stage[r_lane*LANE_W +: LANE_W] <= in_data;
                        r_mask[r_lane]                   <= 1'b1;
                        r_remaining                      <= r_remaining - LEN_W'(1);
                        if (w_last_lane || w_last_word)
                            r_state <= ST_WR_COMMIT;
                        else
                            r_lane <= r_lane + LANE_CW'(1);
                    end
                end

                // Staging is cleared so a partial entry never carries stale lanes.
                ST_WR_COMMIT: begin
                    r_mask  <= '0;
                    r_stage <= '0;
                    r_lane  <= '0;
                    r_ptr   <= ptr_inc(r_ptr);
                    r_state <= (r_remaining == '0) ? ST_IDLE : ST_WR_COLLECT;
                end

                ST_RD_FETCH: begin
                    r_rdbuf <= rf_DOB;
                    r_state <= ST_RD_DRAIN;
                end

                ST_RD_DRAIN: begin
                    if (out_ready) begin
                        r_remaining <= r_remaining - LEN_W'(1);
                        if (w_last_lane || w_last_word) begin
                            r_lane  <= '0;
                            r_ptr   <= ptr_inc(r_ptr);
                            r_state <= w_last_word ? ST_IDLE : ST_RD_FETCH;
                        end else begin
                            r_lane <= r_lane + LANE_CW'(1);
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign cmd_ready = (r_state == ST_IDLE);
    assign busy      = (r_state != ST_IDLE);
    assign err       = r_err;
    assign in_ready  = (r_state == ST_WR_COLLECT);
    assign out_valid = (r_state == ST_RD_DRAIN);
    assign out_data  = r_rdbuf[r_lane*LANE_W +: LANE_W];

    // Port controls decode purely from registered state and counters.
    assign rf_CSA  = (r_state == ST_WR_COMMIT);
    assign rf_WEAN = (r_state != ST_WR_COMMIT);
    assign rf_OEA  = 1'b0;
    assign rf_A    = (r_state == ST_WR_COMMIT) ? r_ptr : '0;
    assign rf_MUXA = (r_state == ST_WR_COMMIT) ? r_mask : '0;
    assign rf_DIA  = r_stage;

    assign rf_CSB  = (r_state == ST_RD_FETCH);
    assign rf_OEB  = (r_state == ST_RD_FETCH);
    assign rf_WEBN = 1'b1;
    assign rf_B    = (r_state == ST_RD_FETCH) ? r_ptr : '0;

endmodule

`default_nettype wire

// File: tb/tb_rf_lane_streamer.sv
// ============================================================================
// Module      : tb_rf_lane_streamer
// Description : Directed bench for rf_lane_streamer with a lane-masked
//               register-file model on ports A/B.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rf_lane_streamer;
    import rf_stream_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                cmd_valid, cmd_ready, cmd_op, err, busy;
    logic [PTR_W-1:0]    cmd_base;
    logic [LEN_W-1:0]    cmd_len;
    logic                in_valid, in_ready;
    logic [LANE_W-1:0]   in_data;
    logic                out_valid, out_ready;
    logic [LANE_W-1:0]   out_data;
    logic [PTR_W-1:0]    rf_A, rf_B;
    logic [ENTRY_W-1:0]  rf_DIA, rf_DOB;
    logic [LANES-1:0]    rf_MUXA;
    logic                rf_CSA, rf_WEAN, rf_OEA, rf_CSB, rf_WEBN, rf_OEB;

    int n_checks = 0;
    int n_errors = 0;

    logic [ENTRY_W-1:0]  mem [DEPTH];
    logic [PTR_W-1:0]    c_addr_q[$];
    logic [LANES-1:0]    c_mask_q[$];
    logic [ENTRY_W-1:0]  c_data_q[$];
    logic [LANE_W-1:0]   out_q[$];
    int                  csa_cnt = 0;
    int                  csb_cnt = 0;

    always #5 clk = ~clk;

    rf_lane_streamer dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_base(cmd_base), .cmd_len(cmd_len), .err(err), .busy(busy),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rf_A(rf_A), .rf_DIA(rf_DIA), .rf_MUXA(rf_MUXA),
        .rf_CSA(rf_CSA), .rf_WEAN(rf_WEAN), .rf_OEA(rf_OEA),
        .rf_B(rf_B), .rf_CSB(rf_CSB), .rf_WEBN(rf_WEBN), .rf_OEB(rf_OEB),
        .rf_DOB(rf_DOB)
    );

    // Register-file model: lane-masked write on port A, combinational read on B.
    assign rf_DOB = (rf_B < PTR_W'(DEPTH)) ? mem[rf_B] : '0;

    always @(posedge clk) begin
        if (rf_CSA) csa_cnt <= csa_cnt + 1;
        if (rf_CSB) csb_cnt <= csb_cnt + 1;
        if (rf_CSA && !rf_WEAN) begin
            c_addr_q.push_back(rf_A);
            c_mask_q.push_back(rf_MUXA);
            c_data_q.push_back(rf_DIA);
            for (int l = 0; l < LANES; l++)
                if (rf_MUXA[l]) mem[rf_A][l*LANE_W +: LANE_W] <= rf_DIA[l*LANE_W +: LANE_W];
        end
        if (out_valid && out_ready) out_q.push_back(out_data);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic op, input logic [PTR_W-1:0] base, input logic [LEN_W-1:0] len);
        cmd_valid = 1'b1; cmd_op = op; cmd_base = base; cmd_len = len;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_word(input logic [LANE_W-1:0] d);
        int n = 0;
        in_valid = 1'b1; in_data = d;
        while (!in_ready && n < 20) begin @(negedge clk); n++; end
        if (n == 20) chk("in_ready_timeout", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin @(negedge clk); n++; end
        chk("idle_reached", 64'(busy), 64'd0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_base = '0; cmd_len = '0;
        in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        chk("rst_streams", {62'd0, in_ready, out_valid}, 64'd0);
        chk("rst_port_ctl", {58'd0, rf_CSA, rf_CSB, rf_OEA, rf_OEB, rf_WEAN, rf_WEBN}, 64'b000011);
        chk("rst_addr_mask", {52'd0, rf_A, rf_B, rf_MUXA}, 64'd0);
        chk("rst_dia", rf_DIA, 64'd0);
        chk("rst_out_data", 64'(out_data), 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Full-entry write: base 2, len 4
        send_cmd(OP_WR, 4'd2, 6'd4);
        chk("wr_first_in_ready", 64'(in_ready), 64'd1);
        chk("wr_cmd_ready_busy", 64'(cmd_ready), 64'd0);
        send_word(16'h1111); send_word(16'h2222); send_word(16'h3333); send_word(16'h4444);
        chk("wr_commit_cycle", {61'd0, rf_CSA, rf_WEAN, in_ready}, 64'b100);
        wait_idle();
        chk("wr1_commits", 64'(c_addr_q.size()), 64'd1);
        chk("wr1_addr", 64'(c_addr_q[0]), 64'd2);
        chk("wr1_mask", 64'(c_mask_q[0]), 64'b1111);
        chk("wr1_dia", c_data_q[0], 64'h4444_3333_2222_1111);

        // Partial final entry: base 5, len 6, entry 6 preloaded
        mem[6] = 64'hDEAD_BEEF_CAFE_F00D;
        send_cmd(OP_WR, 4'd5, 6'd6);
        for (int w = 1; w <= 6; w++) send_word(16'h0500 + 16'(w));
        wait_idle();
        chk("wr2_commits", 64'(c_addr_q.size()), 64'd3);
        chk("wr2_addr0", 64'(c_addr_q[1]), 64'd5);
        chk("wr2_mask0", 64'(c_mask_q[1]), 64'b1111);
        chk("wr2_dia0", c_data_q[1], 64'h0504_0503_0502_0501);
        chk("wr2_addr1", 64'(c_addr_q[2]), 64'd6);
        chk("wr2_mask1", 64'(c_mask_q[2]), 64'b0011);
        chk("wr2_dia1_low", 64'(c_data_q[2][31:0]), 64'h0506_0505);

        // Read back entry 6: upper lanes must keep their old contents
        send_cmd(OP_RD, 4'd6, 6'd4);
        out_ready = 1'b1;
        wait_idle();
        out_ready = 1'b0;
        chk("rd6_count", 64'(out_q.size()), 64'd4);
        chk("rd6_words", {out_q[3], out_q[2], out_q[1], out_q[0]}, 64'hDEAD_BEEF_0506_0505);
        out_q.delete();

        // Wrapping read with backpressure: base 9, len 8
        mem[9] = 64'h9003_9002_9001_9000;
        mem[0] = 64'h0003_0002_0001_0000;
        send_cmd(OP_RD, 4'd9, 6'd8);
        chk("rd_fetch_ctl", {57'd0, out_valid, rf_CSB, rf_OEB, rf_B}, {57'd0, 3'b011, 4'd9});
        @(negedge clk);
        chk("rd_first_valid", {47'd0, out_valid, out_data}, {47'd0, 1'b1, 16'h9000});
        @(negedge clk);
        chk("rd_hold", {47'd0, out_valid, out_data}, {47'd0, 1'b1, 16'h9000});
        for (int c = 0; c < 200 && out_q.size() < 8; c++) begin
            out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        out_ready = 1'b0;
        wait_idle();
        chk("rd_wrap_count", 64'(out_q.size()), 64'd8);
        if (out_q.size() == 8) begin
            chk("rd_wrap_e9", {out_q[3], out_q[2], out_q[1], out_q[0]}, 64'h9003_9002_9001_9000);
            chk("rd_wrap_e0", {out_q[7], out_q[6], out_q[5], out_q[4]}, 64'h0003_0002_0001_0000);
        end
        out_q.delete();

        // Rejected commands
        for (int k = 0; k < 3; k++) begin
            int a0, b0;
            logic [PTR_W-1:0] bb;
            logic [LEN_W-1:0] ll;
            bb = (k == 2) ? 4'd10 : 4'd0;
            ll = (k == 0) ? 6'd0 : ((k == 1) ? 6'd41 : 6'd4);
            a0 = csa_cnt; b0 = csb_cnt;
            send_cmd(k[0], bb, ll);
            chk($sformatf("bad%0d_err", k), {62'd0, err, cmd_ready}, 64'b11);
            @(negedge clk);
            chk($sformatf("bad%0d_err_end", k), {61'd0, err, cmd_ready, busy}, 64'b010);
            chk($sformatf("bad%0d_no_rf", k), 64'(csa_cnt - a0 + csb_cnt - b0), 64'd0);
        end

        // Reset after 3 words of a len-4 write
        send_cmd(OP_WR, 4'd3, 6'd4);
        send_word(16'hAAAA); send_word(16'hBBBB); send_word(16'hCCCC);
        #1 reset = 1'b1;
        #1;
        chk("arst_state", {61'd0, busy, in_ready, cmd_ready}, 64'b001);
        chk("arst_port_a", {59'd0, rf_CSA, rf_WEAN, rf_MUXA[2:0]}, 64'b01000);
        chk("arst_dia", rf_DIA, 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("arst_no_commit", 64'(c_addr_q.size()), 64'd3);
        chk("arst_mem3", mem[3], 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
